di_hall_decode: RTL and testbench

DI_HALL_DECODE -- requirements
Module: di_hall_decode

---
 rtl/hall_pkg.sv | 55 +++++
 rtl/hall_input_filter.sv | 76 +++++++
 rtl/di_hall_decode.sv | 144 ++++++++++++++
 tb/tb_di_hall_decode.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// -----------------------------------------------------------------------------
// hall_pkg
// Shared definitions for three-channel hall sensor handling, used by the
// decoder and by the hall output generator.
//   - hall_phase_e  : sensor phasing encoding (60 or 120 electrical degrees)
//   - FWD_60/FWD_120: forward next-state tables, 3 bits per code, code 0 in
//                     bits [2:0]; illegal codes map to themselves so they never
//                     match a legal step
//   - ILLEGAL_60/120: one bit per code, set for codes that cannot occur
//   - hall_fwd_next : table lookup for the forward successor of a code
//   - hall_illegal  : illegal-code test for the selected phasing
// -----------------------------------------------------------------------------
package hall_pkg;

    typedef enum logic {
        PHASE_60  = 1'b0,
        PHASE_120 = 1'b1
    } hall_phase_e;

    // Entries listed from code 7 down to code 0.
    // 60 deg forward: 000>100>110>111>011>001>000
    localparam logic [23:0] FWD_60  = {3'b011, 3'b111, 3'b101, 3'b110,
                                       3'b001, 3'b010, 3'b000, 3'b100};
    // 120 deg forward: 100>110>010>011>001>101>100
    localparam logic [23:0] FWD_120 = {3'b111, 3'b010, 3'b100, 3'b110,
                                       3'b001, 3'b011, 3'b101, 3'b000};

    localparam logic [7:0] ILLEGAL_60  = 8'b0010_0100;  // 010, 101
    localparam logic [7:0] ILLEGAL_120 = 8'b1000_0001;  // 000, 111

    function automatic logic [2:0] hall_fwd_next(input logic [2:0] code,
                                                 input logic       phase);
        logic [23:0] tbl;
        logic [4:0]  idx;
        if (phase == PHASE_120) begin
            tbl = FWD_120;
        end else begin
            tbl = FWD_60;
        end
        idx = {1'b0, code, 1'b0} + {2'b00, code};  // 3 * code
        return tbl[idx +: 3];
    endfunction

    function automatic logic hall_illegal(input logic [2:0] code,
                                          input logic       phase);
        logic [7:0] mask;
        if (phase == PHASE_120) begin
            mask = ILLEGAL_120;
        end else begin
            mask = ILLEGAL_60;
        end
        return mask[code];
    endfunction

endpackage

// File: rtl/hall_input_filter.sv
// -----------------------------------------------------------------------------
// hall_input_filter
// Two-flop synchronizers on the three hall inputs followed by a run-length
// debounce. A pattern is accepted once the synchronized value has been seen
// FILTER_LEN consecutive times and differs from the last accepted pattern
// (the very first pattern after reset is always accepted).
// Ports:
//   xclk     : system clock, rising edge
//   reset    : asynchronous active-low reset
//   hall_raw : asynchronous {A,B,C} hall inputs
//   pattern  : accepted pattern (new value already visible while change=1)
//   change   : one-cycle strobe, high in the cycle a new pattern is accepted
// -----------------------------------------------------------------------------
module hall_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic       xclk,
    input  logic       reset,
    input  logic [2:0] hall_raw,
    output logic [2:0] pattern,
    output logic       change
);

    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    logic [2:0] sync1_r;
    logic [2:0] sync2_r;
    logic [3:0] run_cnt_r;
    logic [2:0] accepted_r;
    logic       have_r;
    logic       accept_s;

    // Acceptance decision and presentation of the accepted pattern.
    always_comb begin
        accept_s = 1'b0;
        if ((run_cnt_r >= FLEN) && (!have_r || (sync2_r != accepted_r))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        pattern = accept_s ? sync2_r : accepted_r;
        change  = accept_s;
    end

    // Synchronizers, run-length counter and accepted-pattern register.
    // run_cnt_r counts how many consecutive samples sync2_r has held its
    // current value; it is computed from sync1_r so the count lines up with
    // the value sync2_r takes on the same edge.
    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            sync1_r    <= 3'b000;
            sync2_r    <= 3'b000;
            run_cnt_r  <= 4'd0;
            accepted_r <= 3'b000;
            have_r     <= 1'b0;
        end else begin
            sync1_r <= hall_raw;
            sync2_r <= sync1_r;
            if (sync1_r != sync2_r) begin
                run_cnt_r <= 4'd1;
            end else if (run_cnt_r >= FLEN) begin
                run_cnt_r <= run_cnt_r;
            end else begin
                run_cnt_r <= run_cnt_r + 4'd1;
            end
            if (accept_s) begin
                accepted_r <= sync2_r;
                have_r     <= 1'b1;
            end else begin
                accepted_r <= accepted_r;
                have_r     <= have_r;
            end
        end
    end

endmodule

// File: rtl/di_hall_decode.sv
// -----------------------------------------------------------------------------
// di_hall_decode
// Decodes three hall sensor inputs into a commutation state, direction,
// signed position count, inter-edge period, sticky error and stall flag.
// Ports:
//   xclk, reset               : 75 MHz clock, asynchronous active-low reset
//   hall_a_in/b_in/c_in       : asynchronous hall inputs
//   hall_phase                : 0 = 60 deg, 1 = 120 deg sensor phasing
//   clr_err                   : synchronous clear of hall_error
//   hall_state                : accepted {A,B,C} pattern
//   hall_dir                  : 1 = forward (A>B>C), 0 = reverse
//   hall_period/period_valid  : cycles between last two valid steps + strobe
//   edge_count                : signed position count (wraps modulo 2^16)
//   hall_error                : sticky illegal pattern/sequence flag
//   stalled                   : no valid step within STALL_LIMIT cycles
// -----------------------------------------------------------------------------
module di_hall_decode
    import hall_pkg::*;
#(
    parameter int          FILTER_LEN  = 4,
    parameter logic [31:0] STALL_LIMIT = 32'd75_000_000
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic        hall_a_in,
    input  logic        hall_b_in,
    input  logic        hall_c_in,
    input  logic        hall_phase,
    input  logic        clr_err,
    output logic [2:0]  hall_state,
    output logic        hall_dir,
    output logic [31:0] hall_period,
    output logic        period_valid,
    output logic [15:0] edge_count,
    output logic        hall_error,
    output logic        stalled
);

    logic [2:0]  pattern_s;
    logic        change_s;
    logic        illegal_s;
    logic        fwd_s;
    logic        rev_s;
    logic        valid_step_s;
    logic        err_event_s;
    logic [31:0] period_cnt_next_s;

    logic        primed_r;
    logic        armed_r;      // a valid step has been seen since reset/stall
    logic [31:0] period_cnt_r;

    hall_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .xclk     (xclk),
        .reset    (reset),
        .hall_raw ({hall_a_in, hall_b_in, hall_c_in}),
        .pattern  (pattern_s),
        .change   (change_s)
    );

    // Classify the newly accepted pattern against the current state.
    always_comb begin
        illegal_s         = hall_illegal(pattern_s, hall_phase);
        fwd_s             = (hall_fwd_next(hall_state, hall_phase) == pattern_s);
        rev_s             = (hall_fwd_next(pattern_s, hall_phase) == hall_state);
        valid_step_s      = 1'b0;
        err_event_s       = 1'b0;
        if (!change_s) begin
            valid_step_s = 1'b0;
            err_event_s  = 1'b0;
        end else if (!primed_r) begin
            // First pattern after reset only primes the state.
            valid_step_s = 1'b0;
            err_event_s  = illegal_s;
        end else begin
            valid_step_s = !illegal_s && (fwd_s || rev_s);
            err_event_s  = illegal_s || !(fwd_s || rev_s);
        end
        if (period_cnt_r == 32'hFFFF_FFFF) begin
            period_cnt_next_s = period_cnt_r;
        end else begin
            period_cnt_next_s = period_cnt_r + 32'd1;
        end
    end

    // State, position, period, stall and error registers.
    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            hall_state   <= 3'b000;
            hall_dir     <= 1'b0;
            hall_period  <= 32'd0;
            period_valid <= 1'b0;
            edge_count   <= 16'd0;
            hall_error   <= 1'b0;
            stalled      <= 1'b0;
            primed_r     <= 1'b0;
            armed_r      <= 1'b0;
            period_cnt_r <= 32'd0;
        end else begin
            if (change_s) begin
                hall_state <= pattern_s;
                primed_r   <= 1'b1;
            end else begin
                hall_state <= hall_state;
                primed_r   <= primed_r;
            end

            if (valid_step_s) begin
                hall_dir     <= fwd_s;
                edge_count   <= fwd_s ? (edge_count + 16'd1) : (edge_count - 16'd1);
                period_cnt_r <= 32'd1;
                stalled      <= 1'b0;
                armed_r      <= 1'b1;
                // No publish on the first step after reset or stall: the
                // count then does not span two real transitions.
                if (armed_r) begin
                    hall_period  <= period_cnt_r;
                    period_valid <= 1'b1;
                end else begin
                    hall_period  <= hall_period;
                    period_valid <= 1'b0;
                end
            end else begin
                hall_dir     <= hall_dir;
                edge_count   <= edge_count;
                period_cnt_r <= period_cnt_next_s;
                hall_period  <= hall_period;
                period_valid <= 1'b0;
                if (period_cnt_next_s >= STALL_LIMIT) begin
                    stalled <= 1'b1;
                    armed_r <= 1'b0;
                end else begin
                    stalled <= stalled;
                    armed_r <= armed_r;
                end
            end

            // A coincident error event wins over the clear.
            hall_error <= err_event_s | (hall_error & ~clr_err);
        end
    end

endmodule

// File: tb/tb_di_hall_decode.sv
// -----------------------------------------------------------------------------
// tb_di_hall_decode
// Directed bench for di_hall_decode. Two instances share all inputs: u_dut
// with a long stall limit for decode/period checks, u_stall with
// STALL_LIMIT=500 for the stall checks. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_di_hall_decode;

    logic        xclk = 1'b0;
    logic        reset;
    logic        hall_a_in, hall_b_in, hall_c_in;
    logic        hall_phase;
    logic        clr_err;

    logic [2:0]  m_state,  s_state;
    logic        m_dir,    s_dir;
    logic [31:0] m_period, s_period;
    logic        m_pv,     s_pv;
    logic [15:0] m_count,  s_count;
    logic        m_err,    s_err;
    logic        m_stall,  s_stall;

    int n_cmp = 0;
    int n_err = 0;
    int pv_main = 0;
    int pv_stall = 0;

    always #5 xclk = ~xclk;

    di_hall_decode #(.FILTER_LEN(4), .STALL_LIMIT(32'd100_000)) u_dut (
        .xclk(xclk), .reset(reset),
        .hall_a_in(hall_a_in), .hall_b_in(hall_b_in), .hall_c_in(hall_c_in),
        .hall_phase(hall_phase), .clr_err(clr_err),
        .hall_state(m_state), .hall_dir(m_dir), .hall_period(m_period),
        .period_valid(m_pv), .edge_count(m_count), .hall_error(m_err),
        .stalled(m_stall)
    );

    di_hall_decode #(.FILTER_LEN(4), .STALL_LIMIT(32'd500)) u_stall (
        .xclk(xclk), .reset(reset),
        .hall_a_in(hall_a_in), .hall_b_in(hall_b_in), .hall_c_in(hall_c_in),
        .hall_phase(hall_phase), .clr_err(clr_err),
        .hall_state(s_state), .hall_dir(s_dir), .hall_period(s_period),
        .period_valid(s_pv), .edge_count(s_count), .hall_error(s_err),
        .stalled(s_stall)
    );

    // Count period_valid strobes seen by each instance.
    always @(posedge xclk) begin
        if (m_pv === 1'b1) pv_main <= pv_main + 1;
        if (s_pv === 1'b1) pv_stall <= pv_stall + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_hall(input logic [2:0] p);
        {hall_a_in, hall_b_in, hall_c_in} = p;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge xclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},  32'(m_state),  32'd0);
        chk({tag, "_dir"},    32'(m_dir),    32'd0);
        chk({tag, "_period"}, m_period,      32'd0);
        chk({tag, "_pv"},     32'(m_pv),     32'd0);
        chk({tag, "_count"},  32'(m_count),  32'd0);
        chk({tag, "_err"},    32'(m_err),    32'd0);
        chk({tag, "_stall"},  32'(m_stall),  32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        hall_phase = 1'b0;
        clr_err    = 1'b0;
        set_hall(3'b000);
        tick(3);
        chk_all_zero("rst0");

        // Stall: no edges after release, u_stall asserts on cycle 500.
        reset = 1'b1;
        tick(499);
        chk("stall_499",   32'(s_stall), 32'd0);
        chk("prime_state", 32'(m_state), 32'd0);
        chk("prime_err",   32'(m_err),   32'd0);
        tick(1);
        chk("stall_500",   32'(s_stall), 32'd1);
        chk("main_nostall", 32'(m_stall), 32'd0);

        // 60 deg 000>100: first valid step, clears stall, no publish.
        set_hall(3'b100);
        tick(6);
        chk("s1_state",     32'(m_state),  32'd4);
        chk("s1_count",     32'(m_count),  32'd1);
        chk("s1_dir",       32'(m_dir),    32'd1);
        chk("s1_pv",        32'(m_pv),     32'd0);
        chk("stall_clear",  32'(s_stall),  32'd0);
        chk("stall_nopv",   32'(s_pv),     32'd0);

        // 100 held 1000 cycles, then 110: one publish of 1000.
        tick(994);
        set_hall(3'b110);
        tick(6);
        chk("s2_state",   32'(m_state), 32'd6);
        chk("s2_count",   32'(m_count), 32'd2);
        chk("s2_dir",     32'(m_dir),   32'd1);
        chk("s2_period",  m_period,     32'd1000);
        chk("s2_pv",      32'(m_pv),    32'd1);
        chk("stall2_period", s_period,  32'd0);
        tick(1);
        chk("s2_pv_off",  32'(m_pv),    32'd0);
        chk("s2_pv_cnt",  32'(pv_main), 32'd1);
        chk("stall_pv_cnt", 32'(pv_stall), 32'd0);

        // 3-cycle glitch on A: ignored.
        set_hall(3'b010);
        tick(3);
        set_hall(3'b110);
        tick(10);
        chk("gl_state",  32'(m_state), 32'd6);
        chk("gl_err",    32'(m_err),   32'd0);
        chk("gl_count",  32'(m_count), 32'd2);
        chk("gl_pv_cnt", 32'(pv_main), 32'd1);

        // Reset in the middle of the second period count.
        reset = 1'b0;
        hall_phase = 1'b1;
        set_hall(3'b101);
        tick(2);
        chk_all_zero("rst1");
        reset = 1'b1;
        tick(8);
        chk("rp_state",  32'(m_state), 32'd5);
        chk("rp_count",  32'(m_count), 32'd0);
        chk("rp_err",    32'(m_err),   32'd0);
        chk("rp_pv_cnt", 32'(pv_main), 32'd1);

        // 120 deg reverse 101>001>011, with exact 2+FILTER_LEN latency.
        set_hall(3'b001);
        tick(5);
        chk("lat_5",    32'(m_state), 32'd5);
        tick(1);
        chk("lat_6",    32'(m_state), 32'd1);
        chk("r1_count", 32'(m_count), 32'h0000_FFFF);
        chk("r1_dir",   32'(m_dir),   32'd0);
        chk("r1_pv",    32'(m_pv),    32'd0);
        set_hall(3'b011);
        tick(6);
        chk("r2_state",  32'(m_state), 32'd3);
        chk("r2_count",  32'(m_count), 32'h0000_FFFE);
        chk("r2_dir",    32'(m_dir),   32'd0);
        chk("r2_err",    32'(m_err),   32'd0);
        chk("r2_pv",     32'(m_pv),    32'd1);
        chk("r2_period", m_period,     32'd6);

        // Reverse to 100, then non-adjacent 100>011.
        set_hall(3'b010); tick(6);
        set_hall(3'b110); tick(6);
        set_hall(3'b100); tick(6);
        chk("r5_count", 32'(m_count), 32'h0000_FFFB);
        set_hall(3'b011);
        tick(6);
        chk("na_err",   32'(m_err),   32'd1);
        chk("na_state", 32'(m_state), 32'd3);
        chk("na_count", 32'(m_count), 32'h0000_FFFB);
        chk("na_pv",    32'(m_pv),    32'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("clr_err",  32'(m_err),   32'd0);

        // Illegal 000 in 120 deg coinciding with clr_err: error stays set.
        set_hall(3'b000);
        tick(5);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("coin_err",   32'(m_err),   32'd1);
        chk("coin_state", 32'(m_state), 32'd0);
        tick(1);
        chk("coin_hold",  32'(m_err),   32'd1);

        // Switch to 60 deg: 000>100 is now a valid forward step.
        hall_phase = 1'b0;
        set_hall(3'b100);
        tick(6);
        chk("ph_count", 32'(m_count), 32'h0000_FFFC);
        chk("ph_dir",   32'(m_dir),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
